divider_unit: RTL
=================

# divider_unit

Iterative 32-bit integer divide/remainder execution unit sitting directly downstream of the integer issue queue's divider port. It accepts one issued uop with operands already read, runs a fixed-latency radix-2 restoring division, and presents the result to the writeback/result bus with a valid/stall handshake. It reports busy so the issue queue withholds further divider uops. It also squashes in-flight work on a branch mispredict older than the uop.

## Interface
Parameters:
- `XLEN`, 32: operand/result width; fixed-latency count equals `XLEN`.

Ports:
- `clk`  in  1  clock, all state on rising edge
- `rst`  in  1  asynchronous, active-low reset
- `IN_uopValid`  in  1  issued divider uop present this cycle
- `IN_srcA`  in  XLEN  dividend
- `IN_srcB`  in  XLEN  divisor
- `IN_opcode`  in  2  0=DIV, 1=DIVU, 2=REM, 3=REMU
- `IN_tagDst`  in  7  physical destination tag
- `IN_nmDst`  in  5  architectural destination; 0 means no writeback
- `IN_sqN`  in  7  uop sequence number
- `IN_branchValid`  in  1  mispredict flush this cycle
- `IN_branchSqN`  in  7  sequence number of mispredicted branch
- `IN_wbStall`  in  1  result bus cannot accept this cycle
- `OUT_busy`  out  1  to issue queue `doNotIssue`; do not issue a divider uop
- `OUT_valid`  out  1  result valid
- `OUT_result`  out  XLEN  quotient or remainder
- `OUT_tagDst`  out  7  destination tag of result
- `OUT_nmDst`  out  5  architectural destination of result
- `OUT_sqN`  out  7  sequence number of result

## Operation
- States: IDLE, RUN, DONE.
- IDLE: when `IN_uopValid` and the uop is not flushed, latch tag/nmDst/sqN/opcode and load the magnitudes |A| and |B|; signed for DIV/REM, raw for DIVU/REMU. Record the result sign: quotient negative iff signs differ; remainder takes the dividend's sign. Clear the 6-bit counter and go to RUN.
- RUN: each cycle, perform one restoring step:
  - remainder' = {rem, q[MSB]} minus B; if nonnegative, keep it and shift in 1; else shift in 0.
  - After `XLEN` steps, go to DONE.
- DONE: drive `OUT_valid`=1 with the sign-corrected result.
  - Stay in DONE while `IN_wbStall`=1; all outputs are held stable.
  - Go to IDLE on the first edge where `IN_wbStall`=0.
- Special cases (RISC-V), still with full latency:
  - Divisor 0: quotient = all ones, remainder = dividend.
  - DIV/REM with `0x80000000 / -1`: quotient = `0x80000000`, remainder = 0.
- Flush: the held uop (or the incoming uop in IDLE) is killed when `IN_branchValid` and $signed(sqN − IN_branchSqN) > 0. On kill, go to IDLE at that edge with `OUT_valid`=0 next cycle. Equal or older sqN survives.
- `OUT_busy` = (state ≠ IDLE) | `IN_uopValid`. This is combinational, so a uop arriving this cycle blocks issue of the next one.
- A uop arriving while state ≠ IDLE is a protocol violation; ignore it and flag it with a simulation assertion.
- `IN_nmDst`=0 uops execute normally; the consumer discards them.

## Timing
- Reset (async assert, sync-safe deassert): state=IDLE, counter=0, `OUT_valid`=0, `OUT_result`/`OUT_tagDst`/`OUT_nmDst`/`OUT_sqN`=0.
- Accept at edge E0. RUN occupies E1..E32. `OUT_valid` is high starting after edge E32 (latency 33 cycles, no stall).
- Throughput: one op per 34 cycles minimum. A new uop is accepted the cycle after DONE exits.
- Flush has priority over completion and stall in every state.
- Reset mid-operation discards all state immediately; no partial result ever appears.
- `OUT_result` width arithmetic: the remainder register is XLEN+1 bits for the subtract sign; sign correction is two's-complement negate at XLEN bits.

## Structure
- Package `div_pkg`: opcode enum (DIV/DIVU/REM/REMU), state enum, sqN/tag widths (7), nmDst width (5).
- Sub-module `div_step`: a combinational single restoring iteration (rem, q, divisor → rem', q'). This keeps the FSM separate from the datapath.

## Test plan
- DIV −7 / 2 → `OUT_result`=0xFFFFFFFD, valid exactly 33 cycles after accept; REM −7 % 2 → 0xFFFFFFFF.
- DIVU 0xFFFFFFFF / 0 → 0xFFFFFFFF; REMU 5 % 0 → 5; DIV 0x80000000 / −1 → 0x80000000, REM → 0.
- Complete with `IN_wbStall` high for 4 cycles → `OUT_valid` and result held 5 cycles, then IDLE; `OUT_busy` low next cycle.
- Uop sqN=10 in RUN, branch sqN=8 → IDLE next cycle, no `OUT_valid`; branch sqN=10 → completes normally.
- Flush in DONE during stall (sqN=0x7F, branch 0x7E, wrap) → `OUT_valid` drops next cycle.
- Async reset asserted at cycle 15 of RUN → all outputs 0 immediately; a new DIVU 100/7 afterwards → 14.

Source files
------------

// File: rtl/div_pkg.sv
// Shared types and widths for the iterative divider.
//   div_op_e    : opcode encoding carried on IN_opcode
//   div_state_e : control FSM states
//   is_younger  : sequence-number age compare with wraparound
package div_pkg;

   localparam int unsigned SQN_W = 7;
   localparam int unsigned TAG_W = 7;
   localparam int unsigned NM_W  = 5;
   localparam int unsigned CNT_W = 6;

   typedef enum logic [1:0] {
      DIV  = 2'd0,
      DIVU = 2'd1,
      REM  = 2'd2,
      REMU = 2'd3
   } div_op_e;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } div_state_e;

   // True when sqn is strictly younger than br; the difference is read as
   // signed so the 7-bit sequence space may wrap.
   function automatic logic is_younger(input logic [SQN_W-1:0] sqn,
                                       input logic [SQN_W-1:0] br);
      logic [SQN_W-1:0] diff;
      diff = sqn - br;
      return ($signed(diff) > 0);
   endfunction

endpackage

// File: rtl/divider_unit_if.sv
// Issue-side / writeback-side bundle of the divider.
//   IN_*  : issued uop, flush request and writeback stall (driven by master)
//   OUT_* : busy back-pressure and the result bus (driven by slave = divider)
interface divider_unit_if #(
   parameter int unsigned XLEN = 32
);
   logic                       IN_uopValid;
   logic [XLEN-1:0]            IN_srcA;
   logic [XLEN-1:0]            IN_srcB;
   logic [1:0]                 IN_opcode;
   logic [div_pkg::TAG_W-1:0]  IN_tagDst;
   logic [div_pkg::NM_W-1:0]   IN_nmDst;
   logic [div_pkg::SQN_W-1:0]  IN_sqN;
   logic                       IN_branchValid;
   logic [div_pkg::SQN_W-1:0]  IN_branchSqN;
   logic                       IN_wbStall;
   logic                       OUT_busy;
   logic                       OUT_valid;
   logic [XLEN-1:0]            OUT_result;
   logic [div_pkg::TAG_W-1:0]  OUT_tagDst;
   logic [div_pkg::NM_W-1:0]   OUT_nmDst;
   logic [div_pkg::SQN_W-1:0]  OUT_sqN;

   modport master (
      output IN_uopValid, IN_srcA, IN_srcB, IN_opcode, IN_tagDst, IN_nmDst, IN_sqN,
             IN_branchValid, IN_branchSqN, IN_wbStall,
      input  OUT_busy, OUT_valid, OUT_result, OUT_tagDst, OUT_nmDst, OUT_sqN
   );

   modport slave (
      input  IN_uopValid, IN_srcA, IN_srcB, IN_opcode, IN_tagDst, IN_nmDst, IN_sqN,
             IN_branchValid, IN_branchSqN, IN_wbStall,
      output OUT_busy, OUT_valid, OUT_result, OUT_tagDst, OUT_nmDst, OUT_sqN
   );

endinterface

// File: rtl/div_step.sv
// One combinational restoring-division iteration.
//   rem_i/q_i     : partial remainder and dividend/quotient shift register
//   divisor_i     : divisor magnitude
//   rem_o/q_o     : values after shifting in one dividend bit and one quotient bit
module div_step #(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] rem_i,
   input  logic [XLEN-1:0] q_i,
   input  logic [XLEN-1:0] divisor_i,
   output logic [XLEN-1:0] rem_o,
   output logic [XLEN-1:0] q_o
);

   logic [XLEN:0] trial;
   logic [XLEN:0] diff;

   always_comb begin
      trial = {rem_i, q_i[XLEN-1]};
      // Extra top bit is the borrow: set means the trial was below the divisor.
      diff  = trial - {1'b0, divisor_i};
      if (diff[XLEN]) begin
         rem_o = trial[XLEN-1:0];
         q_o   = {q_i[XLEN-2:0], 1'b0};
      end else begin
         rem_o = diff[XLEN-1:0];
         q_o   = {q_i[XLEN-2:0], 1'b1};
      end
   end

endmodule

// File: rtl/divider_unit.sv
// Iterative XLEN-bit DIV/DIVU/REM/REMU unit, fixed XLEN-step latency.
//   clk  : clock
//   rst  : asynchronous active-low reset
//   bus  : divider_unit_if.slave -- issued uop in, busy and result bus out,
//          branch flush and writeback stall in
module divider_unit
   import div_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input logic           clk,
   input logic           rst,
   divider_unit_if.slave bus
);

   div_state_e        state_q, state_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic [XLEN-1:0]   rem_q, rem_d;
   logic [XLEN-1:0]   quo_q, quo_d;
   logic [XLEN-1:0]   dsr_q, dsr_d;
   logic [XLEN-1:0]   result_q, result_d;
   div_op_e           op_q, op_d;
   logic              qneg_q, qneg_d;
   logic              rneg_q, rneg_d;
   logic              dz_q, dz_d;
   logic [TAG_W-1:0]  tag_q, tag_d;
   logic [NM_W-1:0]   nm_q, nm_d;
   logic [SQN_W-1:0]  sqn_q, sqn_d;

   logic              kill;
   logic              accept;
   logic              last_step;
   logic              op_signed;
   logic              a_neg;
   logic              b_neg;
   logic [XLEN-1:0]   a_mag;
   logic [XLEN-1:0]   b_mag;
   logic [XLEN-1:0]   step_rem;
   logic [XLEN-1:0]   step_q;
   logic [XLEN-1:0]   q_fix;
   logic [XLEN-1:0]   r_fix;

   div_step #(.XLEN(XLEN)) u_step (
      .rem_i     (rem_q),
      .q_i       (quo_q),
      .divisor_i (dsr_q),
      .rem_o     (step_rem),
      .q_o       (step_q)
   );

   // In IDLE the candidate for a flush is the incoming uop, otherwise the held one.
   always_comb begin : ctrl_terms
      kill      = bus.IN_branchValid &&
                  is_younger((state_q == IDLE) ? bus.IN_sqN : sqn_q, bus.IN_branchSqN);
      accept    = (state_q == IDLE) && bus.IN_uopValid && !kill;
      last_step = (cnt_q == CNT_W'(XLEN - 1));
   end

   always_comb begin : operand_prep
      op_signed = (bus.IN_opcode == DIV) || (bus.IN_opcode == REM);
      a_neg     = op_signed && bus.IN_srcA[XLEN-1];
      b_neg     = op_signed && bus.IN_srcB[XLEN-1];
      a_mag     = a_neg ? ('0 - bus.IN_srcA) : bus.IN_srcA;
      b_mag     = b_neg ? ('0 - bus.IN_srcB) : bus.IN_srcB;
   end

   // A zero divisor leaves q=all ones and rem=|A|, so only the signed quotient
   // needs overriding; remainder sign correction already restores the dividend.
   always_comb begin : result_fix
      q_fix = dz_q ? '1 : (qneg_q ? ('0 - step_q) : step_q);
      r_fix = rneg_q ? ('0 - step_rem) : step_rem;
   end

   always_comb begin : datapath_next
      cnt_d    = cnt_q;
      rem_d    = rem_q;
      quo_d    = quo_q;
      dsr_d    = dsr_q;
      result_d = result_q;
      op_d     = op_q;
      qneg_d   = qneg_q;
      rneg_d   = rneg_q;
      dz_d     = dz_q;
      tag_d    = tag_q;
      nm_d     = nm_q;
      sqn_d    = sqn_q;
      if (accept) begin
         op_d   = div_op_e'(bus.IN_opcode);
         tag_d  = bus.IN_tagDst;
         nm_d   = bus.IN_nmDst;
         sqn_d  = bus.IN_sqN;
         rem_d  = '0;
         quo_d  = a_mag;
         dsr_d  = b_mag;
         cnt_d  = '0;
         qneg_d = a_neg ^ b_neg;
         rneg_d = a_neg;
         dz_d   = (bus.IN_srcB == '0);
      end else if ((state_q == RUN) && !kill) begin
         rem_d = step_rem;
         quo_d = step_q;
         cnt_d = cnt_q + 1'b1;
         if (last_step) begin
            result_d = ((op_q == DIV) || (op_q == DIVU)) ? q_fix : r_fix;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin : state_reg
      if (!rst) begin
         state_q  <= IDLE;
         cnt_q    <= '0;
         rem_q    <= '0;
         quo_q    <= '0;
         dsr_q    <= '0;
         result_q <= '0;
         op_q     <= DIV;
         qneg_q   <= 1'b0;
         rneg_q   <= 1'b0;
         dz_q     <= 1'b0;
         tag_q    <= '0;
         nm_q     <= '0;
         sqn_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         rem_q    <= rem_d;
         quo_q    <= quo_d;
         dsr_q    <= dsr_d;
         result_q <= result_d;
         op_q     <= op_d;
         qneg_q   <= qneg_d;
         rneg_q   <= rneg_d;
         dz_q     <= dz_d;
         tag_q    <= tag_d;
         nm_q     <= nm_d;
         sqn_q    <= sqn_d;
      end
   end

   // Flush outranks both completion and stall.
   always_comb begin : next_state
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = RUN;
         RUN: begin
            if (kill)           state_d = IDLE;
            else if (last_step) state_d = DONE;
         end
         DONE:    if (kill || !bus.IN_wbStall) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin : outputs
      bus.OUT_busy   = (state_q != IDLE) || bus.IN_uopValid;
      bus.OUT_valid  = (state_q == DONE);
      bus.OUT_result = result_q;
      bus.OUT_tagDst = tag_q;
      bus.OUT_nmDst  = nm_q;
      bus.OUT_sqN    = sqn_q;
   end

   no_issue_while_busy: assert property (
      @(posedge clk) disable iff (!rst) !(bus.IN_uopValid && (state_q != IDLE))
   ) else $error("divider_unit: uop issued while unit is busy");

endmodule
